// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fixup at the end.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               is_div_reg, is_div_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;

  // Operand magnitudes: signed ops strip the sign, unsigned ops pass raw bits.
  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             can_accept;

  assign signed_op  = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag      = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag      = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign can_accept = start && !cancel && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // Multiply step: acc = {partial product high, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_acc;
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_ge    = !div_diff[WIDTH];
  assign div_acc   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    is_div_next = is_div_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (can_accept) begin
          case (op)
            OP_MTHI: hi_next = operand_a;
            OP_MTLO: lo_next = operand_a;
            OP_MULT, OP_MULTU: begin
              state_next  = S_MUL;
              cnt_next    = '0;
              acc_next    = {{WIDTH{1'b0}}, b_mag};
              opnd_next   = a_mag;
              neg_q_next  = signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              neg_r_next  = 1'b0;
              is_div_next = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_next  = S_DIV;
              cnt_next    = '0;
              acc_next    = {{WIDTH{1'b0}}, a_mag};
              opnd_next   = b_mag;
              neg_q_next  = signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              neg_r_next  = signed_op && operand_a[WIDTH-1];
              is_div_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_next = S_IDLE;
        end else begin
          acc_next = mul_acc;
          cnt_next = cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) state_next = S_FIX;
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_next = S_IDLE;
        end else begin
          acc_next = div_acc;
          cnt_next = cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) state_next = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DONE;
          if (is_div_reg) begin
            lo_next = quo_fix;
            hi_next = rem_fix;
          end else begin
            lo_next = prod_fix[WIDTH-1:0];
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      is_div_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      is_div_reg <= is_div_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign busy = (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX);
  assign done = (state_reg == S_DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected {hi,lo}, a monitor
// pops and compares on every done pulse; random ops use a plain-arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural results from ordinary 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] v1, v2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin v1 = sa * sb; return v1; end
      3'd1: begin v1 = ua * ub; return v1; end
      3'd2: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        sq = sa / sb; sr = sa % sb;
        v1 = sq; v2 = sr;
        return {v2[31:0], v1[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        uq = ua / ub; ur = ua % ub;
        v1 = uq; v2 = ur;
        return {v2[31:0], v1[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one start cycle; if now=0 it first waits for the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    bit got;
    got = 1'b0; lat = 0; bcnt = 0;
    while (!got && lat < 200) begin
      lat++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected 34", lat);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", hi, lo);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] done hi=%h lo=%h", hi, lo);
          chk("result", {hi, lo}, e);
        end
      end
    end
  end

  initial begin
    int lat, bcnt;
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [2:0] ro;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b1;

    // MTHI then MTLO back-to-back
    @(negedge clk);
    start = 1'b1; op = 3'd4; operand_a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
    chk("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    op = 3'd5; operand_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h9ABCDEF0});
    chk("mtlo_busy_done", {62'd0, busy, done}, 64'd0);
    $display("[TB] mthi/mtlo hi=%h lo=%h", hi, lo);

    // Reserved op is ignored
    issue(3'd6, 32'h55555555, 32'd1, 64'd0, 1'b0, 1'b0);
    chk("reserved_busy", {63'd0, busy}, 64'd0);
    chk("reserved_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

    // MULTU max x max: latency and busy length
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 1'b1, 1'b0);
    wait_done(lat, bcnt);
    chk("multu_latency", 64'(lat), 64'd34);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);

    issue(3'd0, 32'hFFFFFFF9, 32'd6, {32'hFFFFFFFF, 32'hFFFFFFD6}, 1'b1, 1'b0);
    wait_done(lat, bcnt);

    // DIV -7/2 with an MTLO attempt while busy
    hold_lo = lo;
    issue(3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1, 1'b0);
    issue(3'd5, 32'hDEADBEEF, 32'd0, 64'd0, 1'b0, 1'b1);
    chk("mtlo_while_busy", {32'd0, lo}, {32'd0, hold_lo});
    chk("busy_during_div", {63'd0, busy}, 64'd1);
    wait_done(lat, bcnt);

    issue(3'd3, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF}, 1'b1, 1'b0);
    wait_done(lat, bcnt);
    chk("divu_by0_latency", 64'(lat), 64'd34);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b1, 1'b0);
    wait_done(lat, bcnt);
    issue(3'd2, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'h00000001}, 1'b1, 1'b0);
    wait_done(lat, bcnt);

    // Cancel a DIVU on cycle 10
    hold_hi = hi; hold_lo = lo;
    issue(3'd3, 32'd1000, 32'd3, 64'd0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy_drop", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel_hilo_kept", {hi, lo}, {hold_hi, hold_lo});
    $display("[TB] cancel hi=%h lo=%h", hi, lo);
    issue(3'd1, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1, 1'b0);
    wait_done(lat, bcnt);

    // Cancel beats a simultaneous MTHI in IDLE
    hold_hi = hi;
    @(negedge clk);
    cancel = 1'b1;
    issue(3'd4, 32'hCAFEF00D, 32'd0, 64'd0, 1'b0, 1'b1);
    cancel = 1'b0;
    chk("cancel_blocks_mthi", {32'd0, hi}, {32'd0, hold_hi});

    // Async reset mid-MUL
    issue(3'd1, 32'h01234567, 32'h89ABCDEF, 64'd0, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_busy", {62'd0, busy, done}, 64'd0);
    $display("[TB] async reset hi=%h lo=%h busy=%b", hi, lo, busy);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {hi, lo, 31'd0, busy}, 96'd0);

    // Back-to-back: new start in the DONE cycle
    issue(3'd3, 32'hDEADBEEF, 32'd7, model(3'd3, 32'hDEADBEEF, 32'd7), 1'b1, 1'b0);
    wait_done(lat, bcnt);
    issue(3'd0, 32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    chk("b2b_latency", 64'(lat - 1), 64'd33);

    // Random ops against the model, some issued back-to-back
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, model(ro, ra, rb), 1'b1, ($urandom_range(0, 1) == 1));
      wait_done(lat, bcnt);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
